// File: rtl/udp_rx_mport.sv
// UDP receive parser: strips the 8-byte header and forwards the payload of datagrams
// whose destination port matches the programmable port table; everything else is dropped.
module udp_rx_mport #(
  parameter int                        P_CHAN_NUM  = 4,
  parameter logic [16*P_CHAN_NUM-1:0]  P_PORT_INIT = {16'h8083, 16'h8082, 16'h8081, 16'h8080},
  parameter bit                        P_CHK_LEN   = 1'b1,
  parameter int                        P_CNT_W     = 16,
  localparam int                       CW          = (P_CHAN_NUM > 1) ? $clog2(P_CHAN_NUM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [CW-1:0]      i_cfg_idx,
  input  logic [15:0]        i_cfg_port,
  input  logic [7:0]         i_ip_data,
  input  logic [15:0]        i_ip_len,
  input  logic               i_ip_last,
  input  logic               i_ip_valid,
  output logic [7:0]         o_udp_data,
  output logic [15:0]        o_udp_len,
  output logic [15:0]        o_udp_src_port,
  output logic [CW-1:0]      o_udp_chan,
  output logic               o_udp_last,
  output logic               o_udp_valid,
  output logic               o_udp_err,
  output logic [P_CNT_W-1:0] o_drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t          state, state_nx;
  logic [15:0]     port_tab [P_CHAN_NUM];
  logic [2:0]      hdr_cnt;
  logic [15:0]     src_port;
  logic [7:0]      dst_hi;
  logic [15:0]     udp_len;
  logic [15:0]     pay_cnt;
  logic            hit_r;
  logic [CW-1:0]   chan_r;
  logic            hit;
  logic [CW-1:0]   hit_idx;
  logic            len_ok;
  logic            accept;
  logic            drop_inc;
  logic            start_pay;
  logic            beat;
  logic            beat_last;
  logic            beat_err;

  // Scanning from the top down leaves the lowest matching index as the winner.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = P_CHAN_NUM - 1; k >= 0; k--) begin
      if (port_tab[k] == {dst_hi, i_ip_data}) begin
        hit     = 1'b1;
        hit_idx = CW'(k);
      end
    end
  end

  always_comb begin
    if (P_CHK_LEN) len_ok = (udp_len == i_ip_len);
    else           len_ok = (udp_len <= i_ip_len);
    accept = hit_r && (udp_len >= 16'd8) && len_ok;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    drop_inc  = 1'b0;
    start_pay = 1'b0;
    beat      = 1'b0;
    beat_last = 1'b0;
    beat_err  = 1'b0;
    if (i_ip_valid) begin
      unique case (state)
        S_IDLE: begin
          if (i_ip_last) drop_inc = 1'b1;
          else           state_nx = S_HDR;
        end
        S_HDR: begin
          if (hdr_cnt == 3'd7) begin
            // A datagram that ends on its checksum byte has no payload left to carry.
            if (accept && (udp_len > 16'd8) && !i_ip_last) begin
              state_nx  = S_PAYLOAD;
              start_pay = 1'b1;
            end else begin
              drop_inc = !(accept && (udp_len == 16'd8));
              state_nx = i_ip_last ? S_IDLE : S_DROP;
            end
          end else if (i_ip_last) begin
            drop_inc = 1'b1;
            state_nx = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          beat = 1'b1;
          if (pay_cnt == o_udp_len) begin
            beat_last = 1'b1;
            state_nx  = i_ip_last ? S_IDLE : S_DROP;
          end else if (i_ip_last) begin
            beat_last = 1'b1;
            beat_err  = 1'b1;
            state_nx  = S_IDLE;
          end
        end
        S_DROP: begin
          if (i_ip_last) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < P_CHAN_NUM; k++) port_tab[k] <= P_PORT_INIT[16*k +: 16];
    end else if (i_cfg_we && (int'(i_cfg_idx) < P_CHAN_NUM)) begin
      port_tab[i_cfg_idx] <= i_cfg_port;
    end
  end

  // Header capture, payload counting and the registered output beat.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hdr_cnt        <= '0;
      src_port       <= '0;
      dst_hi         <= '0;
      udp_len        <= '0;
      pay_cnt        <= '0;
      hit_r          <= 1'b0;
      chan_r         <= '0;
      o_udp_data     <= '0;
      o_udp_len      <= '0;
      o_udp_src_port <= '0;
      o_udp_chan     <= '0;
      o_udp_last     <= 1'b0;
      o_udp_valid    <= 1'b0;
      o_udp_err      <= 1'b0;
      o_drop_cnt     <= '0;
    end else begin
      o_udp_valid <= beat;
      o_udp_last  <= beat_last;
      o_udp_err   <= beat_err;
      if (beat) begin
        o_udp_data <= i_ip_data;
        pay_cnt    <= pay_cnt + 16'd1;
      end
      if (i_ip_valid && (state == S_IDLE)) begin
        src_port[15:8] <= i_ip_data;
        hdr_cnt        <= 3'd1;
      end
      if (i_ip_valid && (state == S_HDR)) begin
        hdr_cnt <= hdr_cnt + 3'd1;
        case (hdr_cnt)
          3'd1: src_port[7:0] <= i_ip_data;
          3'd2: dst_hi        <= i_ip_data;
          3'd3: begin
            hit_r  <= hit;
            chan_r <= hit_idx;
          end
          3'd4: udp_len[15:8] <= i_ip_data;
          3'd5: udp_len[7:0]  <= i_ip_data;
          default: ;
        endcase
      end
      if (start_pay) begin
        o_udp_len      <= udp_len - 16'd8;
        o_udp_src_port <= src_port;
        o_udp_chan     <= chan_r;
        pay_cnt        <= 16'd1;
      end
      if (drop_inc && !(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + P_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_rx_mport.sv
// Bench for udp_rx_mport: one strict-length and one relaxed-length instance share the
// same input stream and are compared every cycle against a per-datagram reference model.
module tb_udp_rx_mport;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we;
  logic [CW-1:0] cfg_idx;
  logic [15:0]   cfg_port;
  logic [7:0]    ip_data;
  logic [15:0]   ip_len_s;
  logic          ip_last;
  logic          ip_valid;

  logic [7:0]    udp_data  [2];
  logic [15:0]   udp_len   [2];
  logic [15:0]   udp_src   [2];
  logic [CW-1:0] udp_chan  [2];
  logic          udp_last  [2];
  logic          udp_valid [2];
  logic          udp_err   [2];
  logic [15:0]   drop_cnt  [2];

  always #5 clk = ~clk;

  udp_rx_mport #(.P_CHK_LEN(1'b0)) dut_nochk (
    .i_clk(clk), .i_rst(rst_n), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_port(cfg_port),
    .i_ip_data(ip_data), .i_ip_len(ip_len_s), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
    .o_udp_data(udp_data[0]), .o_udp_len(udp_len[0]), .o_udp_src_port(udp_src[0]),
    .o_udp_chan(udp_chan[0]), .o_udp_last(udp_last[0]), .o_udp_valid(udp_valid[0]),
    .o_udp_err(udp_err[0]), .o_drop_cnt(drop_cnt[0])
  );

  udp_rx_mport #(.P_CHK_LEN(1'b1)) dut_chk (
    .i_clk(clk), .i_rst(rst_n), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_port(cfg_port),
    .i_ip_data(ip_data), .i_ip_len(ip_len_s), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
    .o_udp_data(udp_data[1]), .o_udp_len(udp_len[1]), .o_udp_src_port(udp_src[1]),
    .o_udp_chan(udp_chan[1]), .o_udp_last(udp_last[1]), .o_udp_valid(udp_valid[1]),
    .o_udp_err(udp_err[1]), .o_drop_cnt(drop_cnt[1])
  );

  typedef struct {
    int            cyc;
    logic [7:0]    data;
    logic          last;
    logic          err;
    logic [15:0]   len;
    logic [15:0]   src;
    logic [CW-1:0] chan;
  } beat_t;

  beat_t         expq [2][$];
  int            exp_drop   [2];
  int            beats_seen [2];
  int            errs_seen  [2];
  logic [15:0]   tab [NCH];
  logic [7:0]    fb  [64];
  bit            bflag [2][64];
  bit            blast [2][64];
  bit            berr  [2][64];
  logic [15:0]   bexp_len  [2];
  logic [15:0]   bexp_src  [2];
  logic [CW-1:0] bexp_chan [2];
  int            cyc;
  int            n_checks;
  int            n_pass;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare both instances against their expected beat queues on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        while (expq[m].size() > 0 && expq[m][0].cyc < cyc) begin
          check($sformatf("d%0d beat_missing", m), 32'd0, 32'd1);
          void'(expq[m].pop_front());
        end
        if (udp_valid[m]) begin
          beats_seen[m]++;
          if (udp_err[m]) errs_seen[m]++;
          if (expq[m].size() == 0) begin
            check($sformatf("d%0d unexpected_beat", m), 32'd1, 32'd0);
          end else begin
            beat_t b;
            b = expq[m].pop_front();
            check($sformatf("d%0d beat_cycle", m), cyc, b.cyc);
            check($sformatf("d%0d data", m), udp_data[m], b.data);
            check($sformatf("d%0d last", m), udp_last[m], b.last);
            check($sformatf("d%0d err", m), udp_err[m], b.err);
            check($sformatf("d%0d len", m), udp_len[m], b.len);
            check($sformatf("d%0d src", m), udp_src[m], b.src);
            check($sformatf("d%0d chan", m), udp_chan[m], b.chan);
          end
        end else begin
          check($sformatf("d%0d idle_flags", m), {udp_last[m], udp_err[m]}, 32'd0);
        end
      end
    end
  end

  // Reference: what a complete n-byte frame must produce; returns the drop increment.
  function automatic int model(input int m, input int n, input int len_ip);
    int src, dst, len, chan, npay;
    bit hit, accept;
    for (int k = 0; k < 64; k++) begin
      bflag[m][k] = 1'b0; blast[m][k] = 1'b0; berr[m][k] = 1'b0;
    end
    if (n < 8) return 1;
    src  = {fb[0], fb[1]};
    dst  = {fb[2], fb[3]};
    len  = {fb[4], fb[5]};
    hit  = 1'b0;
    chan = 0;
    for (int k = NCH - 1; k >= 0; k--) if (tab[k] == dst) begin hit = 1'b1; chan = k; end
    accept = hit && (len >= 8) && ((m == 1) ? (len == len_ip) : (len <= len_ip));
    if (!accept) return 1;
    if (len == 8) return 0;
    if (n == 8) return 1;
    npay = (len - 8 < n - 8) ? len - 8 : n - 8;
    for (int i = 0; i < npay; i++) begin
      bflag[m][8+i] = 1'b1;
      blast[m][8+i] = (i == npay - 1);
      berr[m][8+i]  = (i == npay - 1) && (n < len);
    end
    bexp_len[m]  = 16'(len - 8);
    bexp_src[m]  = 16'(src);
    bexp_chan[m] = CW'(chan);
    return 0;
  endfunction

  task automatic mkFrame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input int n);
    fb[0] = src[15:8]; fb[1] = src[7:0];
    fb[2] = dst[15:8]; fb[3] = dst[7:0];
    fb[4] = len[15:8]; fb[5] = len[7:0];
    fb[6] = 8'($urandom); fb[7] = 8'($urandom);
    for (int k = 8; k < n; k++) fb[k] = 8'($urandom);
  endtask

  // Drives fb[0..n-1] (stopping early after 'cut' bytes) with random idle gaps of gap %.
  task automatic applyStimulus(input int n, input int len_ip, input int gap, input int cut);
    int d [2];
    for (int m = 0; m < 2; m++) d[m] = model(m, n, len_ip);
    ip_len_s = 16'(len_ip);
    for (int k = 0; k < n && k < cut; k++) begin
      while ($urandom_range(99) < gap) begin
        ip_valid = 1'b0; ip_last = 1'b0;
        @(negedge clk);
      end
      ip_valid = 1'b1; ip_data = fb[k]; ip_last = (k == n - 1);
      for (int m = 0; m < 2; m++)
        if (bflag[m][k])
          expq[m].push_back('{cyc: cyc + 1, data: fb[k], last: blast[m][k], err: berr[m][k],
                              len: bexp_len[m], src: bexp_src[m], chan: bexp_chan[m]});
      @(negedge clk);
    end
    ip_valid = 1'b0; ip_last = 1'b0;
    if (cut >= n) for (int m = 0; m < 2; m++) exp_drop[m] += d[m];
  endtask

  task automatic checkOutput(input string tag);
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s d%0d drop_cnt", tag, m), drop_cnt[m], exp_drop[m]);
      check($sformatf("%s d%0d queue_drained", tag, m), expq[m].size(), 32'd0);
    end
  endtask

  task automatic cfgWrite(input int idx, input logic [15:0] port);
    cfg_we = 1'b1; cfg_idx = CW'(idx); cfg_port = port;
    @(negedge clk);
    cfg_we = 1'b0;
    tab[idx] = port;
  endtask

  task automatic checkReset(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s d%0d outputs", tag, m),
            {udp_data[m], udp_chan[m], udp_last[m], udp_valid[m], udp_err[m]}, 32'd0);
      check($sformatf("%s d%0d len_src", tag, m), {udp_len[m], udp_src[m]}, 32'd0);
      check($sformatf("%s d%0d drop_cnt", tag, m), drop_cnt[m], 32'd0);
    end
  endtask

  task automatic resetTable();
    tab[0] = 16'h8080; tab[1] = 16'h8081; tab[2] = 16'h8082; tab[3] = 16'h8083;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0 [2];
    int e0 [2];
    logic [7:0] f1 [12];
    logic [15:0] ports [6];
    n_checks = 0; n_pass = 0; cyc = 0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_port = '0;
    ip_data = '0; ip_len_s = '0; ip_last = 1'b0; ip_valid = 1'b0;
    resetTable();
    f1 = '{8'h80, 8'h80, 8'h80, 8'h81, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08};
    ports = '{16'h8080, 16'h8081, 16'h8082, 16'h8083, 16'h9000, 16'h1234};

    repeat (3) @(negedge clk);
    checkReset("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkReset("after_release");

    // Basic frame to port 8081.
    for (int k = 0; k < 12; k++) fb[k] = f1[k];
    b0 = beats_seen;
    applyStimulus(12, 12, 0, 99);
    check("model chan", bexp_chan[1], 32'd1);
    check("model len", bexp_len[1], 32'd4);
    check("model src", bexp_src[1], 32'h8080);
    checkOutput("basic");
    check("basic d1 beats", beats_seen[1] - b0[1], 32'd4);

    // Unknown port 9000, then program it into entry 2.
    mkFrame(16'h4321, 16'h9000, 16'd12, 12);
    b0 = beats_seen;
    applyStimulus(12, 12, 0, 99);
    checkOutput("noport");
    check("noport d0 drop literal", drop_cnt[0], 32'd1);
    check("noport d1 beats", beats_seen[1] - b0[1], 32'd0);
    cfgWrite(2, 16'h9000);
    b0 = beats_seen;
    applyStimulus(12, 12, 0, 99);
    check("model chan after write", bexp_chan[0], 32'd2);
    checkOutput("newport");
    check("newport d0 beats", beats_seen[0] - b0[0], 32'd4);

    // UDP length 10 inside a 12-byte IP payload.
    mkFrame(16'h1111, 16'h8080, 16'h000A, 12);
    b0 = beats_seen;
    applyStimulus(12, 12, 0, 99);
    checkOutput("shortlen");
    check("shortlen d1 drop literal", drop_cnt[1], 32'd2);
    check("shortlen d0 drop literal", drop_cnt[0], 32'd1);
    check("shortlen d0 beats", beats_seen[0] - b0[0], 32'd2);

    // Truncated datagram: length 16 but the frame ends on payload byte 2.
    mkFrame(16'h2222, 16'h8081, 16'h0010, 10);
    b0 = beats_seen; e0 = errs_seen;
    applyStimulus(10, 16, 0, 99);
    checkOutput("trunc");
    check("trunc d0 beats", beats_seen[0] - b0[0], 32'd2);
    check("trunc d0 errs", errs_seen[0] - e0[0], 32'd1);
    mkFrame(16'h3333, 16'h8080, 16'd12, 12);
    applyStimulus(12, 12, 0, 99);
    checkOutput("after_trunc");

    // Randomized frames with 30% idle gaps and occasional table rewrites.
    for (int t = 0; t < 40; t++) begin
      int n, len, r;
      logic [15:0] dst;
      n   = ($urandom_range(1) == 0) ? 9 : 12;
      r   = $urandom_range(3);
      len = (r == 0) ? n : (r == 1) ? n - 1 : (r == 2) ? n + 2 : 7;
      dst = ($urandom_range(3) != 0) ? tab[$urandom_range(NCH - 1)] : 16'h1234;
      mkFrame(16'($urandom), dst, 16'(len), n);
      applyStimulus(n, n, 30, 99);
      if ($urandom_range(4) == 0) cfgWrite($urandom_range(NCH - 1), ports[$urandom_range(5)]);
    end
    checkOutput("random");

    // Reset in the middle of a payload.
    mkFrame(16'h5555, tab[0], 16'd20, 20);
    applyStimulus(20, 20, 0, 12);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("mid_reset");
    for (int m = 0; m < 2; m++) begin
      expq[m].delete();
      exp_drop[m] = 0;
    end
    resetTable();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mkFrame(16'h6666, 16'h8082, 16'd12, 12);
    b0 = beats_seen;
    applyStimulus(12, 12, 0, 99);
    check("model chan after reset", bexp_chan[1], 32'd2);
    checkOutput("post_reset");
    check("post_reset d1 beats", beats_seen[1] - b0[1], 32'd4);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udp_rx_mport.md
Name: udp_rx_mport

Overview:
Multi-channel UDP receive parser between the IP receive layer and the application payload consumers. It takes the 8-bit IP payload stream and parses the 8-byte UDP header. The destination port is matched against a runtime-programmable table of P_CHAN_NUM ports. On a match, the block strips the header and forwards the payload, tagged with the channel index and source port. Malformed or unmatched datagrams are discarded and counted.

Parameters:
P_CHAN_NUM, 4, number of port-table entries/channels (1..16)
P_PORT_INIT, {16'h8083,16'h8082,16'h8081,16'h8080}, reset contents of the port table; entry k sits at bits [16k+15:16k]
P_CHK_LEN, 1, 1 = drop a datagram if the UDP length field differs from i_ip_len; 0 = only require the length field to be >= 8 and <= i_ip_len
P_CNT_W, 16, drop-counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_cfg_we  in  1  port-table write strobe
i_cfg_idx  in  $clog2(P_CHAN_NUM) (min 1)  table entry to write
i_cfg_port  in  16  port value to write
i_ip_data  in  8  IP payload byte
i_ip_len  in  16  IP payload length in bytes, stable for the whole frame
i_ip_last  in  1  last byte of the frame
i_ip_valid  in  1  byte valid; gaps are allowed within a frame
o_udp_data  out  8  UDP payload byte
o_udp_len  out  16  payload length (UDP length field - 8)
o_udp_src_port  out  16  source port of the datagram
o_udp_chan  out  $clog2(P_CHAN_NUM) (min 1)  index of the matched channel
o_udp_last  out  1  last payload byte
o_udp_valid  out  1  payload byte valid
o_udp_err  out  1  asserted with o_udp_last when the datagram was truncated
o_drop_cnt  out  P_CNT_W  number of dropped datagrams, saturating

Behaviour:
- Reset (i_rst=0, async): all outputs 0, o_drop_cnt=0, port table reloaded from P_PORT_INIT, FSM to IDLE. The first valid byte after reset release is header byte 0.
- Byte counter and FSM advance only when i_ip_valid=1.
- FSM states: IDLE, HDR, PAYLOAD, DROP.
- IDLE: a valid byte loads header byte 0 and moves to HDR.
- HDR: header bytes 0-1 are the source port, 2-3 the destination port, 4-5 the length, 6-7 the checksum (ignored). All multi-byte fields are big-endian.
- Port lookup: compares {byte2,byte3} against every table entry at byte 3. The lowest matching index wins. A table write in the same cycle as the lookup does not affect it (old value is used).
- Decision at byte 7:
  - Accept only if a port matched, length >= 8, and the length rule set by P_CHK_LEN holds.
  - Accept and length > 8: go to PAYLOAD.
  - Accept and length == 8: no output, no drop count; go to DROP, or to IDLE if i_ip_last=1.
  - Reject: o_drop_cnt += 1; go to DROP, or to IDLE if i_ip_last=1.
- i_ip_last during HDR before byte 7: drop, o_drop_cnt += 1, go to IDLE.
- PAYLOAD:
  - Each valid input byte appears on o_udp_data with o_udp_valid=1 exactly 1 cycle later (registered).
  - o_udp_len, o_udp_src_port and o_udp_chan are held constant for the whole datagram.
  - o_udp_last is asserted on payload byte number (length-8).
  - If i_ip_last coincides with that byte, go to IDLE; otherwise go to DROP to discard IP padding.
  - If i_ip_last arrives earlier: o_udp_last=1 and o_udp_err=1 on that byte, o_drop_cnt unchanged, go to IDLE.
- DROP: discard bytes until i_ip_last, then go to IDLE. No output.
- o_udp_valid, o_udp_last and o_udp_err are single-cycle per beat and are 0 when no beat is presented.
- Table write: takes effect the cycle after i_cfg_we. An out-of-range i_cfg_idx is ignored.
- o_drop_cnt saturates at all-ones.
- No backpressure: the downstream consumer must accept one byte per cycle.

Test Plan:
- Frame: header 80 80 80 81 00 0C 00 00 + payload 05 06 07 08, i_ip_len=12 -> 4 beats 05..08, each 1 cycle after input; o_udp_chan=1, o_udp_len=4, o_udp_src_port=16'h8080; o_udp_last on 08.
- Destination port 16'h9000 with default table -> no output, o_drop_cnt 0->1. Then write entry 2 = 16'h9000 and resend -> payload delivered with o_udp_chan=2.
- P_CHK_LEN=1: UDP length 00 0A with i_ip_len=12 -> dropped, count+1. P_CHK_LEN=0, same frame -> 2 payload beats, last 2 padding bytes discarded, o_udp_last on payload byte 2.
- i_ip_last on payload byte 2 of a length-16 datagram with P_CHK_LEN=0 -> o_udp_last=o_udp_err=1 on byte 2; the next frame parses normally.
- Random i_ip_valid gaps (30% idle) over 9-byte and 12-byte frames -> output bytes identical in order and count to the gapless case.
- i_rst low mid-payload -> all outputs 0 immediately, table back to P_PORT_INIT, counter 0; the following frame is parsed correctly.
